// File: rtl/mem_dma.sv
// mem_dma: word-granular copy/fill engine driving the single-cycle data
// memory port. Copy reads one word then writes it (two cycles per word);
// fill writes a latched pattern (one cycle per word). Every output comes
// straight from a flop; the flop inputs are derived from the next state so
// the bus values line up with the state they belong to.

module mem_dma #(
    parameter int LEN_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      fill_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] count,
    output logic             mem_we,
    output logic [31:0]      mem_a,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] CNT_ONE  = LEN_W'(1);
    localparam logic [31:0]      WORD_B   = 32'd4;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [31:0]      src_q, src_d;
    logic [31:0]      dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [31:0]      data_q, data_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_a_q, mem_a_d;
    logic [31:0]      mem_wd_q, mem_wd_d;

    // Next-state and transfer-register update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        data_d  = data_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    count_d = CNT_ZERO;
                    if ((dst_addr[1:0] != 2'b00) ||
                        ((mode == 1'b0) && (src_addr[1:0] != 2'b00))) begin
                        // Rejected request: no memory access at all.
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (len == CNT_ZERO) begin
                        state_d = S_DONE;
                    end else if (mode == 1'b1) begin
                        data_d  = fill_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                data_d  = mem_rd;
                src_d   = src_q + WORD_B;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                dst_d   = dst_q + WORD_B;
                count_d = count_q + CNT_ONE;
                if ((count_q + CNT_ONE) == len_q) begin
                    state_d = S_DONE;
                end else if (mode_q == 1'b1) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output flop inputs, derived from the state being entered.
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        mem_we_d = 1'b0;
        mem_a_d  = 32'd0;
        mem_wd_d = 32'd0;
        case (state_d)
            S_READ: begin
                busy_d  = 1'b1;
                mem_a_d = src_d;
            end
            S_WRITE: begin
                busy_d   = 1'b1;
                mem_we_d = 1'b1;
                mem_a_d  = dst_d;
                mem_wd_d = data_d;
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            S_IDLE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, transfer registers and registered outputs; reset clears all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            src_q    <= 32'd0;
            dst_q    <= 32'd0;
            len_q    <= CNT_ZERO;
            count_q  <= CNT_ZERO;
            data_q   <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
            mem_a_q  <= 32'd0;
            mem_wd_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            count_q  <= count_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            mem_we_q <= mem_we_d;
            mem_a_q  <= mem_a_d;
            mem_wd_q <= mem_wd_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign count  = count_q;
    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;

endmodule
